// File: rtl/fetch_controller.sv
// fetch_controller: sequential instruction fetch into a 2-entry prefetch FIFO.
// A redirect flushes the buffer and restarts fetch at redirect_pc.
// Optional halt detection is compiled in with the macro FETCH_HALT_DETECT_EN.
// When it is defined, fetching stops after HALT_WORD has been pushed and only
// a redirect restarts it.
module fetch_controller #(
    parameter logic [9:0]  RESET_PC  = 10'd0,
    parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [9:0]  imem_addr,
    input  logic [15:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [9:0]  redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr,
    output logic [9:0]  instr_pc,
    output logic        halted
);

    localparam int DEPTH = 2;

    logic [9:0]  fetch_pc_reg, fetch_pc_next;
    logic [1:0]  count_reg, count_next;
    logic        wr_ptr_reg, wr_ptr_next;
    logic        rd_ptr_reg, rd_ptr_next;
    logic [25:0] entry_q [DEPTH];   // {pc, instr} per FIFO slot
    logic        pop;
    logic        push;
    logic        run_active;

    assign instr_valid = (count_reg != 2'd0);
    // Pop only happens with a valid head, so an empty FIFO is never popped.
    assign pop         = instr_valid & instr_ready;
    // A full FIFO only accepts a push when the head leaves in the same cycle.
    assign push        = run_active & ~redirect_valid & ((count_reg != 2'd2) | pop);

    assign imem_addr           = fetch_pc_reg;
    assign {instr_pc, instr}   = entry_q[rd_ptr_reg];

`ifdef FETCH_HALT_DETECT_EN
    typedef enum logic {
        st_run  = 1'b0,
        st_halt = 1'b1
    } state_t;

    state_t state_reg, state_next;

    // Next state: redirect always restarts fetch and beats halt detection.
    always_comb begin
        state_next = state_reg;
        if (redirect_valid) begin
            state_next = st_run;
        end else if (push && (imem_instr == HALT_WORD)) begin
            state_next = st_halt;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= st_run;
        end else begin
            state_reg <= state_next;
        end
    end

    assign run_active = (state_reg == st_run);
    assign halted     = (state_reg == st_halt);
`else
    // Without halt detection the halt encoding is an ordinary instruction.
    logic [15:0] unused_halt_word;
    assign unused_halt_word = HALT_WORD;
    assign run_active       = 1'b1;
    assign halted           = 1'b0;
`endif

    // Next-state for fetch pointer, occupancy and FIFO pointers.
    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        count_next    = count_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        if (redirect_valid) begin
            // Flush: a head handshaken this cycle is simply dropped from the
            // buffer, which is what delivering it means here.
            fetch_pc_next = redirect_pc;
            count_next    = 2'd0;
            wr_ptr_next   = 1'b0;
            rd_ptr_next   = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_next   = ~wr_ptr_reg;
                fetch_pc_next = fetch_pc_reg + 10'd1;   // wraps 1023 -> 0
            end
            if (pop) begin
                rd_ptr_next = ~rd_ptr_reg;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + 2'd1;
                2'b01:   count_next = count_reg - 2'd1;
                default: count_next = count_reg;
            endcase
        end
    end

    // Control registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg <= RESET_PC;
            count_reg    <= 2'd0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            count_reg    <= count_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
        end
    end

    // One register per FIFO slot; cleared on reset so the head reads as 0.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
            logic [25:0] entry_reg;
            logic        entry_we;

            assign entry_we = push & (wr_ptr_reg == 1'(gi));

            // Capture {fetch_pc, imem_instr} when this slot is written.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= 26'd0;
                end else if (entry_we) begin
                    entry_reg <= {fetch_pc_reg, imem_instr};
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

endmodule
